lap_store: RTL and testbench

LAP_STORE -- requirements
Module: lap_store

---
 rtl/lap_store.sv | 133 +++++++++++++
 tb/tb_lap_store.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lap_store.sv
// lap_store: circular lap-record buffer with age-relative, one-cycle registered reads.
// Optional feature macro LAP_STORE_OVERWRITE_EN: a write while full replaces the oldest record.
module lap_store #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_index,
  output logic [WIDTH-1:0]  data_out,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
`ifdef LAP_STORE_OVERWRITE_EN
  localparam logic OVERWRITE_C = 1'b1;
`else
  localparam logic OVERWRITE_C = 1'b0;
`endif

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_base_q,  rd_base_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic              overflow_q, overflow_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              mem_we_s;
  logic              full_s;
  logic              empty_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              rd_hit_s;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == '0);

  // Write-side next state: clear wins, then append, then full-buffer handling.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_base_d  = rd_base_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_we_s   = 1'b0;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_base_d  = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (wr_en) begin
      if (!full_s) begin
        mem_we_s = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        count_d  = count_q + (ADDR_W+1)'(1);
      end else begin
        overflow_d = 1'b1;
        if (OVERWRITE_C) begin
          // Oldest slot is the one wr_ptr points at; the window slides by one.
          mem_we_s  = 1'b1;
          wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
          rd_base_d = rd_base_q + ADDR_W'(1);
        end else begin
          mem_we_s = 1'b0;
        end
      end
    end else begin
      mem_we_s = 1'b0;
    end
  end

  assign rd_addr_s = rd_base_q + rd_index;
  assign rd_hit_s  = ({1'b0, rd_index} < count_q);

  // Read-side next state, sampled from pre-write contents and count.
  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    if (clr) begin
      data_out_d = '0;
    end else if (rd_en) begin
      if (rd_hit_s) begin
        data_out_d = mem_q[rd_addr_s];
        rd_valid_d = 1'b1;
      end else begin
        data_out_d = '0;
      end
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_base_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_base_q  <= rd_base_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Record storage; deliberately not reset, unreadable until written.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign full     = full_s;
  assign empty    = empty_s;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_lap_store.sv
// Self-checking bench for lap_store: directed scenarios plus randomized traffic against a queue model.
module tb_lap_store;
  localparam int WIDTH  = 24;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst, clr, wr_en, rd_en;
  logic [WIDTH-1:0]  data_in;
  logic [ADDR_W-1:0] rd_index;
  logic [WIDTH-1:0]  data_out;
  logic              rd_valid, full, empty, overflow;
  logic [ADDR_W:0]   count;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid, m_ovf;

  lap_store #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .rd_index(rd_index), .data_out(data_out), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Reference: a queue of records, oldest at the front; reads see the state before this edge's write.
  task automatic model_step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                            input logic [ADDR_W-1:0] idx, input logic c);
    if (c) begin
      model_reset();
    end else begin
      m_valid = 1'b0;
      if (r) begin
        if (int'(idx) < mq.size()) begin
          m_dout  = mq[idx];
          m_valid = 1'b1;
        end else begin
          m_dout = '0;
        end
      end
      if (w) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(d);
        end else begin
          m_ovf = 1'b1;
`ifdef LAP_STORE_OVERWRITE_EN
          void'(mq.pop_front());
          mq.push_back(d);
`endif
        end
      end
    end
  endtask

  task automatic apply(input logic w, input logic [WIDTH-1:0] d, input logic r,
                       input logic [ADDR_W-1:0] idx, input logic c);
    wr_en = w; data_in = d; rd_en = r; rd_index = idx; clr = c;
    @(posedge clk);
    #1;
    model_step(w, d, r, idx, c);
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++;
    if ({full, empty} !== 2'b01) begin miscompares++; $display("FAIL reset_full_empty: got %b want 01", {full, empty}); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    vectors++;
    if ({rd_valid, data_out} !== 25'd0) begin miscompares++; $display("FAIL reset_read: got valid=%b data=%h want 0/0", rd_valid, data_out); end
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    pulse_reset();
    for (int i = 1; i <= 3; i++) apply(1'b1, WIDTH'(i), 1'b0, 4'd0, 1'b0);
    vectors++;
    if (count !== 5'd3 || empty !== 1'b0) begin miscompares++; $display("FAIL basic_count: got count=%0d empty=%b want 3/0", count, empty); end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 24'h0, 1'b1, ADDR_W'(i), 1'b0);
      vectors++;
      if (data_out !== WIDTH'(i + 1) || rd_valid !== 1'b1) begin
        miscompares++; $display("FAIL basic_read idx%0d: got %h/%b want %h/1", i, data_out, rd_valid, WIDTH'(i + 1));
      end
    end
    apply(1'b0, 24'h0, 1'b1, 4'd5, 1'b0);
    vectors++;
    if (data_out !== 24'h0 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL beyond_count: got %h/%b want 0/0", data_out, rd_valid); end
    apply(1'b0, 24'h0, 1'b1, 4'd1, 1'b0);
    apply(1'b0, 24'h0, 1'b0, 4'd0, 1'b0);
    vectors++;
    if (data_out !== 24'h2 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL idle_hold: got %h/%b want 000002/0", data_out, rd_valid); end
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] exp0, exp15;
`ifdef LAP_STORE_OVERWRITE_EN
    exp0 = 24'h11; exp15 = 24'h20;
`else
    exp0 = 24'h10; exp15 = 24'h1F;
`endif
    pulse_reset();
    for (int i = 0; i < 17; i++) apply(1'b1, WIDTH'(16 + i), 1'b0, 4'd0, 1'b0);
    vectors++;
    if ({full, empty, overflow} !== 3'b101 || count !== 5'd16) begin
      miscompares++; $display("FAIL fill_flags: got full=%b empty=%b ovf=%b count=%0d want 1/0/1/16", full, empty, overflow, count);
    end
    apply(1'b0, 24'h0, 1'b1, 4'd0, 1'b0);
    vectors++;
    if (data_out !== exp0 || rd_valid !== 1'b1) begin miscompares++; $display("FAIL fill_idx0: got %h/%b want %h/1", data_out, rd_valid, exp0); end
    apply(1'b0, 24'h0, 1'b1, 4'd15, 1'b0);
    vectors++;
    if (data_out !== exp15 || rd_valid !== 1'b1) begin miscompares++; $display("FAIL fill_idx15: got %h/%b want %h/1", data_out, rd_valid, exp15); end
    apply(1'b0, 24'h0, 1'b0, 4'd0, 1'b1);
    vectors++;
    if ({overflow, empty, count} !== {1'b0, 1'b1, 5'd0}) begin
      miscompares++; $display("FAIL fill_clr: got ovf=%b empty=%b count=%0d want 0/1/0", overflow, empty, count);
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    apply(1'b1, 24'h111111, 1'b0, 4'd0, 1'b0);
    apply(1'b1, 24'h222222, 1'b0, 4'd0, 1'b0);
    apply(1'b1, 24'hABCDEF, 1'b1, 4'd2, 1'b0);
    vectors++;
    if (rd_valid !== 1'b0 || data_out !== 24'h0) begin miscompares++; $display("FAIL rw_same_cycle: got %h/%b want 0/0", data_out, rd_valid); end
    apply(1'b0, 24'h0, 1'b1, 4'd2, 1'b0);
    vectors++;
    if (data_out !== 24'hABCDEF || rd_valid !== 1'b1 || count !== 5'd3) begin
      miscompares++; $display("FAIL rw_after: got %h/%b count=%0d want abcdef/1/3", data_out, rd_valid, count);
    end
  endtask

  task automatic test_clear_and_reset();
    pulse_reset();
    for (int i = 0; i < 4; i++) apply(1'b1, WIDTH'(32'h300 + i), 1'b0, 4'd0, 1'b0);
    apply(1'b1, 24'h777777, 1'b1, 4'd0, 1'b1);
    vectors++;
    if ({count, overflow, empty, rd_valid} !== {5'd0, 1'b0, 1'b1, 1'b0} || data_out !== 24'h0) begin
      miscompares++; $display("FAIL clr_priority: got count=%0d ovf=%b empty=%b valid=%b data=%h want 0/0/1/0/0", count, overflow, empty, rd_valid, data_out);
    end
    apply(1'b1, 24'h000AAA, 1'b0, 4'd0, 1'b0);
    apply(1'b0, 24'h0, 1'b1, 4'd0, 1'b0);
    vectors++;
    if (rd_valid !== 1'b1 || data_out !== 24'h000AAA) begin miscompares++; $display("FAIL read_after_clr: got %h/%b want 000aaa/1", data_out, rd_valid); end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (rd_valid !== 1'b0 || data_out !== 24'h0 || count !== 5'd0) begin
      miscompares++; $display("FAIL rst_async: got valid=%b data=%h count=%0d want 0/0/0", rd_valid, data_out, count);
    end
    rd_en = 1'b1; rd_index = 4'd0;
    @(posedge clk);
    #1;
    vectors++;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_read: got valid=%b want 0", rd_valid); end
    rd_en = 1'b0;
    rst = 1'b0;
    model_reset();
    apply(1'b1, 24'h5A5A5A, 1'b0, 4'd0, 1'b0);
    apply(1'b0, 24'h0, 1'b1, 4'd0, 1'b0);
    vectors++;
    if (data_out !== 24'h5A5A5A || rd_valid !== 1'b1 || count !== 5'd1) begin
      miscompares++; $display("FAIL first_after_rst: got %h/%b count=%0d want 5a5a5a/1/1", data_out, rd_valid, count);
    end
  endtask

  task automatic test_random();
    logic [32:0] got, exp;
    pulse_reset();
    for (int n = 0; n < 600; n++) begin
      logic w, r, c;
      w = (n < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 1) == 1;
      c = $urandom_range(0, 59) == 0;
      apply(w, WIDTH'($urandom), r, ADDR_W'($urandom_range(0, DEPTH - 1)), c);
      exp = {m_dout, m_valid, 5'(mq.size()), (mq.size() == DEPTH), (mq.size() == 0), m_ovf};
      got = {data_out, rd_valid, count, full, empty, overflow};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random cyc%0d: got data=%h v=%b cnt=%0d f=%b e=%b o=%b want data=%h v=%b cnt=%0d f=%b e=%b o=%b",
                 n, got[32:9], got[8], got[7:3], got[2], got[1], got[0],
                 exp[32:9], exp[8], exp[7:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0; rd_index = '0;
    model_reset();
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_clear_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
